// File: rtl/edge_evt_pkg.sv
// Shared constants and helpers for the edge-event arbiter.
package edge_evt_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_TS_W  = 16;

    function automatic int id_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/edge_evt_rr_pick.sv
// Combinational round-robin finder: first set request at or above ptr, wrapping.
module edge_evt_rr_pick
    import edge_evt_pkg::*;
#(
    parameter int  WIDTH = DEF_WIDTH,
    localparam int ID_W  = id_width(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             any,
    output logic [ID_W-1:0]  idx,
    output logic [WIDTH-1:0] grant
);

    always_comb begin
        logic [ID_W-1:0] pos;
        any = 1'b0;
        idx = '0;
        pos = '0;
        for (int off = 0; off < WIDTH; off++) begin
            pos = ID_W'((int'(ptr) + off) % WIDTH);
            if (!any && req[pos]) begin
                any = 1'b1;
                idx = pos;
            end
        end
    end

    assign grant = any ? (WIDTH'(1) << idx) : '0;

endmodule

// File: rtl/edge_event_arbiter.sv
// Turns 0->1 flag transitions into a round-robin valid/ready stream of bit indices.
// Optional per-event rise timestamps when EDGE_EVT_TIMESTAMP_EN is defined.
module edge_event_arbiter
    import edge_evt_pkg::*;
#(
    parameter int  WIDTH = DEF_WIDTH,
    parameter int  TS_W  = DEF_TS_W,
    localparam int ID_W  = id_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] flags,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [ID_W-1:0]  evt_id,
`ifdef EDGE_EVT_TIMESTAMP_EN
    output logic [TS_W-1:0]  evt_ts,
`endif
    output logic [WIDTH-1:0] pending,
    output logic [WIDTH-1:0] overflow
);

    if (WIDTH < 2 || TS_W < 1) begin : g_bad_params
        $error("edge_event_arbiter: WIDTH must be >= 2 and TS_W >= 1");
    end

    logic [WIDTH-1:0] flags_r;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] grant;
    logic [WIDTH-1:0] pick_grant;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  pick_idx;
    logic             pick_any;
    logic             slot_free;

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] i);
        return (i == ID_W'(WIDTH - 1)) ? '0 : i + ID_W'(1);
    endfunction

    assign rise      = flags & ~flags_r;
    assign slot_free = !evt_valid || evt_ready;
    assign grant     = slot_free ? pick_grant : '0;

    edge_evt_rr_pick #(
        .WIDTH (WIDTH)
    ) u_pick (
        .req   (pending),
        .ptr   (ptr),
        .any   (pick_any),
        .idx   (pick_idx),
        .grant (pick_grant)
    );

    // A rise on a bit being granted this cycle re-arms it instead of overflowing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_r   <= '0;
            pending   <= '0;
            overflow  <= '0;
            ptr       <= '0;
            evt_valid <= 1'b0;
            evt_id    <= '0;
        end else begin
            flags_r  <= flags;
            pending  <= (pending & ~grant) | rise;
            overflow <= overflow | (rise & pending & ~grant);
            if (slot_free) begin
                evt_valid <= pick_any;
                if (pick_any) begin
                    evt_id <= pick_idx;
                    ptr    <= wrap_inc(pick_idx);
                end
            end
        end
    end

`ifdef EDGE_EVT_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;
    logic [TS_W-1:0] stamp [WIDTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_cnt <= '0;
            evt_ts <= '0;
        end else begin
            ts_cnt <= ts_cnt + TS_W'(1);
            if (slot_free && pick_any) begin
                evt_ts <= stamp[pick_idx];
            end
        end
    end

    // Keep the first stamp while an older event for the same bit is still waiting.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WIDTH; i++) begin
            if (rise[i] && !(pending[i] && !grant[i])) begin
                stamp[i] <= ts_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Self-checking bench for edge_event_arbiter: directed table, hand sequences, random vs model.
module tb_edge_event_arbiter;

    logic        clk;
    logic        reset;
    logic [31:0] flags;
    logic        evt_valid;
    logic        evt_ready;
    logic [4:0]  evt_id;
    logic [31:0] pending;
    logic [31:0] overflow;
`ifdef EDGE_EVT_TIMESTAMP_EN
    logic [15:0] evt_ts;
`endif

    edge_event_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .flags     (flags),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
`ifdef EDGE_EVT_TIMESTAMP_EN
        .evt_ts    (evt_ts),
`endif
        .pending   (pending),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: sets of pending/overflow bits, a one-entry output slot, and a search pointer.
    logic [31:0] m_prev, m_pend, m_ovf;
    logic        m_valid;
    int          m_id, m_ptr;
    int          m_cnt;
    int          m_stamp [32];
    int          m_ts;

    task automatic model_reset();
        m_prev = '0; m_pend = '0; m_ovf = '0;
        m_valid = 1'b0; m_id = 0; m_ptr = 0; m_cnt = 0; m_ts = 0;
    endtask

    task automatic model_step(input logic [31:0] f, input logic rdy);
        int  g;
        int  j;
        bit  free;
        bit  r;
        g = -1;
        free = !m_valid || rdy;
        if (free) begin
            for (int off = 0; off < 32; off++) begin
                j = (m_ptr + off) % 32;
                if (g < 0 && m_pend[j]) g = j;
            end
        end
        if (g >= 0) m_ts = m_stamp[g];
        for (int i = 0; i < 32; i++) begin
            r = f[i] && !m_prev[i];
            if (r && !(m_pend[i] && i != g)) m_stamp[i] = m_cnt;
            if (r && m_pend[i] && i != g) m_ovf[i] = 1'b1;
            m_pend[i] = (m_pend[i] && i != g) || r;
            m_prev[i] = f[i];
        end
        if (free) begin
            if (g >= 0) begin
                m_valid = 1'b1;
                m_id    = g;
                m_ptr   = (g + 1) % 32;
            end else begin
                m_valid = 1'b0;
            end
        end
        m_cnt = (m_cnt + 1) % 65536;
    endtask

    task automatic compare_model();
        check("model_valid", {31'b0, evt_valid}, {31'b0, m_valid});
        check("model_pending", pending, m_pend);
        check("model_overflow", overflow, m_ovf);
        if (m_valid) begin
            check("model_id", 32'(evt_id), m_id);
`ifdef EDGE_EVT_TIMESTAMP_EN
            check("model_ts", 32'(evt_ts), m_ts);
`endif
        end
    endtask

    // Called at posedge+1: drive inputs, take one edge, compare against the model.
    task automatic cycle(input logic [31:0] f, input logic rdy);
        flags = f;
        evt_ready = rdy;
        @(posedge clk);
        model_step(f, rdy);
        #1;
        compare_model();
    endtask

    typedef struct {
        logic [31:0] flags;
        logic        ready;
        logic        exp_valid;
        logic [4:0]  exp_id;
        logic [31:0] exp_pend;
    } vec_t;

    vec_t tbl [5];
    int   id5_seen;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{32'h8000_0003, 1'b1, 1'b0, 5'd0,  32'h8000_0003};
        tbl[1] = '{32'h8000_0003, 1'b1, 1'b1, 5'd0,  32'h8000_0002};
        tbl[2] = '{32'h8000_0003, 1'b1, 1'b1, 5'd1,  32'h8000_0000};
        tbl[3] = '{32'h8000_0003, 1'b1, 1'b1, 5'd31, 32'h0000_0000};
        tbl[4] = '{32'h8000_0003, 1'b1, 1'b0, 5'd0,  32'h0000_0000};

        // Reset held with all flags high.
        reset = 1'b0;
        flags = 32'hFFFF_FFFF;
        evt_ready = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'b0, evt_valid}, 32'd0);
        check("rst_pending", pending, 32'd0);
        check("rst_overflow", overflow, 32'd0);
        check("rst_id", 32'(evt_id), 32'd0);

        // Release with flags still high: ids 0..31 back to back.
        reset = 1'b1;
        cycle(32'hFFFF_FFFF, 1'b1);
        check("rel_pending", pending, 32'hFFFF_FFFF);
        check("rel_valid", {31'b0, evt_valid}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            cycle(32'hFFFF_FFFF, 1'b1);
            check("rel_seq_valid", {31'b0, evt_valid}, 32'd1);
            check("rel_seq_id", 32'(evt_id), i);
        end
        cycle(32'hFFFF_FFFF, 1'b1);
        check("rel_drain_valid", {31'b0, evt_valid}, 32'd0);
        cycle(32'h0, 1'b1);
        cycle(32'h0, 1'b1);

        // Table: three simultaneous rises served 0, 1, 31.
        for (int k = 0; k < 5; k++) begin
            cycle(tbl[k].flags, tbl[k].ready);
            check("tbl_valid", {31'b0, evt_valid}, {31'b0, tbl[k].exp_valid});
            check("tbl_pending", pending, tbl[k].exp_pend);
            if (tbl[k].exp_valid) check("tbl_id", 32'(evt_id), 32'(tbl[k].exp_id));
        end
        cycle(32'h0, 1'b1);

        // Single flag: pending after edge k, event after k+1 for one cycle.
        cycle(32'h1, 1'b1);
        check("single_pend", pending, 32'h1);
        check("single_valid0", {31'b0, evt_valid}, 32'd0);
        cycle(32'h1, 1'b1);
        check("single_valid1", {31'b0, evt_valid}, 32'd1);
        check("single_id", 32'(evt_id), 32'd0);
        check("single_pend_clr", pending, 32'h0);
        cycle(32'h1, 1'b1);
        check("single_valid2", {31'b0, evt_valid}, 32'd0);
        cycle(32'h0, 1'b1);

        // Overflow: slot occupied by id 2, flag 5 rises twice while pending.
        cycle(32'h04, 1'b0);
        cycle(32'h04, 1'b0);
        check("ovf_hold_id", 32'(evt_id), 32'd2);
        cycle(32'h24, 1'b0);
        cycle(32'h04, 1'b0);
        check("ovf_not_yet", overflow, 32'h0);
        cycle(32'h24, 1'b0);
        check("ovf_set", overflow, 32'h20);
        id5_seen = 0;
        for (int k = 0; k < 6; k++) begin
            cycle(32'h24, 1'b1);
            if (evt_valid && evt_id == 5'd5) id5_seen++;
        end
        check("ovf_one_event", id5_seen, 32'd1);
        check("ovf_sticky", overflow, 32'h20);
        cycle(32'h0, 1'b1);

        // Wrap: id 31 granted, then 0 and 31 pending -> 0 first, stall, then 31.
        cycle(32'h8000_0000, 1'b1);
        cycle(32'h0000_0000, 1'b1);
        check("wrap_id31", 32'(evt_id), 32'd31);
        cycle(32'h8000_0001, 1'b1);
        check("wrap_pend", pending, 32'h8000_0001);
        cycle(32'h8000_0001, 1'b0);
        check("wrap_id0", 32'(evt_id), 32'd0);
        for (int k = 0; k < 3; k++) begin
            cycle(32'h8000_0001, 1'b0);
            check("stall_valid", {31'b0, evt_valid}, 32'd1);
            check("stall_id", 32'(evt_id), 32'd0);
        end
        cycle(32'h8000_0001, 1'b1);
        check("wrap_then31", 32'(evt_id), 32'd31);
        cycle(32'h8000_0001, 1'b1);
        check("wrap_idle", {31'b0, evt_valid}, 32'd0);
        cycle(32'h0, 1'b1);

        // Asynchronous reset mid-transfer.
        cycle(32'hF1, 1'b0);
        cycle(32'hF1, 1'b0);
        check("pre_rst_valid", {31'b0, evt_valid}, 32'd1);
        check("pre_rst_pending", pending, 32'hF0);
        #2;
        reset = 1'b0;
        #1;
        check("async_valid", {31'b0, evt_valid}, 32'd0);
        check("async_pending", pending, 32'd0);
        check("async_overflow", overflow, 32'd0);
        model_reset();
        flags = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Randomised traffic with sparse flag toggles against the model.
        for (int k = 0; k < 1500; k++) begin
            logic [31:0] nf;
            nf = flags ^ ($urandom & $urandom & $urandom);
            cycle(nf, $urandom_range(0, 3) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/edge_event_arbiter.md
# edge_event_arbiter

Downstream consumer of the 32-bit sticky edge-flag vector produced by the edge-capture stage. Detects each flag's 0→1 transition, holds it as a pending event, and serialises pending events round-robin into a single valid/ready event stream of bit indices. A flag re-asserting while its previous event is still pending is recorded in a sticky per-bit overflow vector.

## Interface
- `WIDTH`, 32: number of flag bits (≥2).
- `TS_W`, 16: timestamp width (used only with the timestamp feature).
- `ID_W` (localparam), `$clog2(WIDTH)`: event-index width.

- `clk`  in  1  sole clock; all state on its rising edge.
- `reset`  in  1  asynchronous, active-low reset; clears all state immediately.
- `flags`  in  WIDTH  sticky edge flags from edge-capture `out`.
- `evt_valid`  out  1  event present on `evt_id`.
- `evt_ready`  in  1  consumer accepts the event when high with `evt_valid`.
- `evt_id`  out  ID_W  index of the flag bit that produced the event.
- `evt_ts`  out  TS_W  cycle stamp of the event's rise (timestamp build only).
- `pending`  out  WIDTH  events detected but not yet loaded to the output.
- `overflow`  out  WIDTH  sticky; bit i set on a lost event for flag i.

## Operation
- `flags_r` holds the registered `flags`. `rise = flags & ~flags_r`. A 1→0 drop (upstream reset) is ignored.
- `pending` next value = `(pending & ~grant) | rise`. `rise` wins over `grant` on the same bit, so the bit stays pending and no overflow is recorded.
- `overflow[i]` is set when `rise[i] & pending[i] & ~grant[i]`. Cleared only by `reset`.
- Output slot is free when `!evt_valid | evt_ready`.
- When the slot is free and `pending != 0`:
  - grant the first set pending bit at or above `ptr`, wrapping modulo WIDTH;
  - load its index into `evt_id` and set `evt_valid=1`;
  - clear that pending bit;
  - set `ptr` to id+1, wrapping WIDTH-1→0.
- When the slot is free and `pending == 0`: `evt_valid` goes to 0 on that edge.
- `evt_id` (and `evt_ts`) stay stable while `evt_valid & !evt_ready`.
- Only the current `pending` is arbitrated. A rise in cycle k cannot be granted in cycle k.

## Timing
- All outputs reset to 0: `evt_valid`, `evt_id`, `evt_ts`, `pending`, `overflow`. Internal `flags_r`, `ptr` and the timestamp counter also reset to 0.
- `flags[i]` first sampled high at edge k:
  - `pending[i]=1` after edge k;
  - `evt_valid=1`, `evt_id=i` after edge k+1, provided the slot is free and no other bit wins.
- Throughput is one event per cycle while `evt_ready` is held high.
- A reset assertion mid-transfer drops `evt_valid` asynchronously and discards the in-flight event and all pending events.
- The first rising edge after reset release samples `flags` against `flags_r=0`, so flags already high then generate events.

## Configuration
- `EDGE_EVT_TIMESTAMP_EN` defined:
  - a free-running TS_W counter runs from 0 after reset, incrementing every cycle and wrapping;
  - a per-bit stamp register captures the counter on `rise[i]`, except when `pending[i]` is already set and not being granted (the first stamp is kept);
  - `evt_ts` loads with `evt_id`.
- Not defined: no counter or stamp storage; `evt_ts` is absent from the port list.

## Structure
- Package `edge_evt_pkg`: default WIDTH and TS_W constants, and a function for ID_W.
- Sub-module `edge_evt_rr_pick`: combinational round-robin finder.
  - Inputs: `req[WIDTH]`, `ptr[ID_W]`.
  - Outputs: `any`, `idx[ID_W]`, one-hot `grant[WIDTH]`.
- The top level holds all registers.

## Test plan
- Hold `reset` low with `flags=0xFFFFFFFF` → `evt_valid=0`, `pending=0`, `overflow=0`. Release with `flags` still high → ids 0..31 in order on consecutive cycles (`evt_ready=1`).
- `flags` 0→0x00000001 at edge k, `evt_ready=1` → `evt_valid=1`, `evt_id=0` after k+1 for exactly one cycle; `pending=0` after k+1. With the macro, `evt_ts` equals the counter value at edge k.
- `flags` 0→0x80000003 at once, `ptr=0`, `evt_ready=1` → ids 0, 1, 31 on three consecutive cycles, then `evt_valid=0`.
- `evt_ready=0`. Flag 5 rises, drops to 0, then rises again → `overflow[5]=1`. After `evt_ready=1`, exactly one id 5 event appears.
- Wrap: after id 31 is granted, bits 0 and 31 are pending → next grant is id 0, then 31. Hold `evt_ready=0` for 3 cycles → `evt_id` is unchanged throughout.
- Assert `reset` between edges while `evt_valid=1` and `pending=0x00F0` → `evt_valid`, `pending` and `overflow` are 0 before the next edge.
